ysyx_22050598_lsu_mem_ctrl: RTL and testbench

- Multi-cycle memory-access controller for the MEM stage.
- Sits between EXU (upstream, valid/ready) and the data-memory bus (8-byte-aligned request/response).
- Replaces direct combinational DPI access: aligns store data and byte masks, issues one bus transaction per accepted request, and extracts/extends load data.
- Returns results to WBU with a valid/ready handshake; flags misaligned accesses and bus timeouts.

---
 rtl/ysyx_22050598_lsu_mem_ctrl_pkg.sv | 31 +++
 rtl/ysyx_22050598_lsu_mem_ctrl_if.sv | 24 ++
 rtl/ysyx_22050598_lsu_mem_ctrl_align.sv | 52 +++++
 rtl/ysyx_22050598_lsu_mem_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_ysyx_22050598_lsu_mem_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22050598_lsu_mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage load/store controller: access sizes,
// FSM state encoding and the data width.
package ysyx_22050598_pkg;

    localparam int XLEN = 64;

    typedef enum logic [1:0] {
        LS_B = 2'b00,
        LS_H = 2'b01,
        LS_W = 2'b10,
        LS_D = 2'b11
    } ls_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_RESP = 2'b11
    } state_e;

    // An access is misaligned when its address is not a multiple of its size.
    function automatic logic is_misaligned(input ls_type_e t, input logic [2:0] loc);
        case (t)
            LS_H:    return loc[0] != 1'b0;
            LS_W:    return loc[1:0] != 2'b00;
            LS_D:    return loc != 3'b000;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22050598_lsu_mem_ctrl_if.sv
// Data-memory bus: one 8-byte-aligned request channel and one response channel.
interface ysyx_22050598_lsu_mem_ctrl_if;
    import ysyx_22050598_pkg::*;

    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_addr;
    logic            mem_wen;
    logic [XLEN-1:0] mem_wdata;
    logic [7:0]      mem_wmask;
    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rsp_rdata;

    modport master (
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );

    modport slave (
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );

endinterface

// File: rtl/ysyx_22050598_lsu_mem_ctrl_align.sv
// Combinational lane steering: replicates store data, builds byte enables and
// extracts/extends load data from an 8-byte-aligned read word.
module ysyx_22050598_lsu_align
    import ysyx_22050598_pkg::*;
(
    input  logic [1:0]      ls_type,
    input  logic [2:0]      loc,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] rdata,
    input  logic            load_unsigned,
    output logic [XLEN-1:0] wdata,
    output logic [7:0]      wmask,
    output logic [XLEN-1:0] load_data
);

    logic [XLEN-1:0] shifted_s;

    assign shifted_s = rdata >> {loc, 3'b000};

    // Size-dependent store replication, byte mask and load extension.
    always_comb begin
        wdata     = store_data;
        wmask     = 8'hFF;
        load_data = shifted_s;
        case (ls_type_e'(ls_type))
            LS_B: begin
                wdata     = {8{store_data[7:0]}};
                wmask     = 8'h01 << loc;
                load_data = load_unsigned ? {56'd0, shifted_s[7:0]}
                                          : {{56{shifted_s[7]}}, shifted_s[7:0]};
            end
            LS_H: begin
                wdata     = {4{store_data[15:0]}};
                wmask     = 8'h03 << loc;
                load_data = load_unsigned ? {48'd0, shifted_s[15:0]}
                                          : {{48{shifted_s[15]}}, shifted_s[15:0]};
            end
            LS_W: begin
                wdata     = {2{store_data[31:0]}};
                wmask     = 8'h0F << loc;
                load_data = load_unsigned ? {32'd0, shifted_s[31:0]}
                                          : {{32{shifted_s[31]}}, shifted_s[31:0]};
            end
            default: begin
                wdata     = store_data;
                wmask     = 8'hFF;
                load_data = shifted_s;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_22050598_lsu_mem_ctrl.sv
// MEM-stage controller: accepts one EXU request, runs one bus transaction and
// hands an aligned/extended result (or misalign/timeout flag) to WBU.
module ysyx_22050598_lsu_mem_ctrl
    import ysyx_22050598_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [XLEN-1:0]             ls_loc,
    input  logic [XLEN-1:0]             store_data,
    input  logic                        load_en,
    input  logic                        store_en,
    input  logic [1:0]                  ls_type,
    input  logic                        load_unsigned,
    ysyx_22050598_lsu_mem_ctrl_if.master mem,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [XLEN-1:0]             out_load_data,
    output logic                        out_misalign,
    output logic                        out_bus_err
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_e          state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, data_q, data_d;
    logic [7:0]      wmask_q, wmask_d;
    logic            wen_q, wen_d, load_q, load_d, uns_q, uns_d;
    logic            mis_q, mis_d, err_q, err_d;
    logic [1:0]      type_q, type_d;
    logic [2:0]      off_q, off_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            idle_s, timeout_hit_s;
    logic [1:0]      al_type_s;
    logic [2:0]      al_off_s;
    logic [XLEN-1:0] al_wdata_s, al_ldata_s;
    logic [7:0]      al_wmask_s;

    // In IDLE the aligner sees the incoming request; afterwards the latched one.
    assign idle_s    = (state_q == ST_IDLE);
    assign al_type_s = idle_s ? ls_type : type_q;
    assign al_off_s  = idle_s ? ls_loc[2:0] : off_q;

    ysyx_22050598_lsu_align u_align (
        .ls_type       (al_type_s),
        .loc           (al_off_s),
        .store_data    (store_data),
        .rdata         (mem.mem_rsp_rdata),
        .load_unsigned (uns_q),
        .wdata         (al_wdata_s),
        .wmask         (al_wmask_s),
        .load_data     (al_ldata_s)
    );

    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign timeout_hit_s = 1'b0;
        end else begin : g_timeout
            assign timeout_hit_s = (cnt_q == CW'(TIMEOUT - 1));
        end
    endgenerate

    // Next-state and next-register logic for the four-state access FSM.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        wen_d   = wen_q;
        load_d  = load_q;
        uns_d   = uns_q;
        type_d  = type_q;
        off_d   = off_q;
        data_d  = data_q;
        mis_d   = mis_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    addr_d  = {ls_loc[XLEN-1:3], 3'b000};
                    type_d  = ls_type;
                    off_d   = ls_loc[2:0];
                    uns_d   = load_unsigned;
                    wen_d   = store_en;
                    load_d  = load_en & ~store_en;
                    wdata_d = store_en ? al_wdata_s : {XLEN{1'b0}};
                    wmask_d = store_en ? al_wmask_s : 8'h00;
                    data_d  = {XLEN{1'b0}};
                    err_d   = 1'b0;
                    mis_d   = 1'b0;
                    if (!(load_en || store_en)) begin
                        state_d = ST_RESP;
                    end else if (is_misaligned(ls_type_e'(ls_type), ls_loc[2:0])) begin
                        mis_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_REQ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem.mem_req_ready) begin
                    state_d = ST_WAIT;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                // A response arriving in the timeout cycle still wins.
                if (mem.mem_rsp_valid) begin
                    data_d  = load_q ? al_ldata_s : {XLEN{1'b0}};
                    state_d = ST_RESP;
                end else if (timeout_hit_s) begin
                    err_d   = 1'b1;
                    data_d  = {XLEN{1'b0}};
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    mis_d   = 1'b0;
                    err_d   = 1'b0;
                    data_d  = {XLEN{1'b0}};
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= {XLEN{1'b0}};
            wdata_q <= {XLEN{1'b0}};
            wmask_q <= 8'h00;
            wen_q   <= 1'b0;
            load_q  <= 1'b0;
            uns_q   <= 1'b0;
            type_q  <= 2'b00;
            off_q   <= 3'b000;
            data_q  <= {XLEN{1'b0}};
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            wen_q   <= wen_d;
            load_q  <= load_d;
            uns_q   <= uns_d;
            type_q  <= type_d;
            off_q   <= off_d;
            data_q  <= data_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready          = idle_s;
    assign out_valid         = (state_q == ST_RESP);
    assign mem.mem_req_valid = (state_q == ST_REQ);
    assign mem.mem_addr      = addr_q;
    assign mem.mem_wen       = wen_q;
    assign mem.mem_wdata     = wdata_q;
    assign mem.mem_wmask     = wmask_q;
    assign out_load_data     = data_q;
    assign out_misalign      = mis_q;
    assign out_bus_err       = err_q;

endmodule

// File: tb/tb_ysyx_22050598_lsu_mem_ctrl.sv
// Scoreboarded bench for the MEM-stage controller, built with TIMEOUT=4.
module tb_ysyx_22050598_lsu_mem_ctrl;

    typedef struct packed {
        logic [63:0] data;
        logic        mis;
        logic        err;
    } res_t;

    typedef struct packed {
        logic [1:0]  t;
        logic [63:0] loc;
        logic [63:0] sd;
        logic        ld;
        logic        st;
        logic        uns;
        logic [63:0] rd;
        logic [7:0]  wmask;
        logic [63:0] wdata;
        logic [63:0] res;
    } pat_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, load_en, store_en, load_unsigned;
    logic        out_valid, out_ready, out_misalign, out_bus_err;
    logic [63:0] ls_loc, store_data, out_load_data;
    logic [1:0]  ls_type;

    int   n_vec = 0;
    int   n_bad = 0;
    int   req_cnt = 0;
    res_t sb[$];

    ysyx_22050598_lsu_mem_ctrl_if mem_if ();

    ysyx_22050598_lsu_mem_ctrl #(.XLEN(64), .TIMEOUT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .ls_loc        (ls_loc),
        .store_data    (store_data),
        .load_en       (load_en),
        .store_en      (store_en),
        .ls_type       (ls_type),
        .load_unsigned (load_unsigned),
        .mem           (mem_if),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_load_data (out_load_data),
        .out_misalign  (out_misalign),
        .out_bus_err   (out_bus_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Result scoreboard and request counter, sampled 2 time units after the edge.
    always begin
        @(posedge clk);
        #2;
        if (mem_if.mem_req_valid && mem_if.mem_req_ready) req_cnt++;
        if (!rst && out_valid && out_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_result got data=%h mis=%0b err=%0b want none", out_load_data, out_misalign, out_bus_err);
            end else begin
                res_t e;
                e = sb.pop_front();
                if ({out_load_data, out_misalign, out_bus_err} !== e) begin
                    n_bad++;
                    $display("FAIL result got data=%h mis=%0b err=%0b want data=%h mis=%0b err=%0b",
                             out_load_data, out_misalign, out_bus_err, e.data, e.mis, e.err);
                end
            end
        end
    end

    task automatic issue(input logic [1:0] t, input logic [63:0] loc, input logic [63:0] sd,
                         input logic ld, input logic st, input logic uns, input res_t e);
        ls_type = t; ls_loc = loc; store_data = sd;
        load_en = ld; store_en = st; load_unsigned = uns;
        in_valid = 1'b1;
        sb.push_back(e);
        step();
        in_valid = 1'b0;
    endtask

    task automatic bus_cycle(input logic [63:0] rd);
        mem_if.mem_req_ready = 1'b1;
        step();
        mem_if.mem_req_ready = 1'b0;
        mem_if.mem_rsp_valid = 1'b1;
        mem_if.mem_rsp_rdata = rd;
        step();
        mem_if.mem_rsp_valid = 1'b0;
        mem_if.mem_rsp_rdata = 64'h5A5A_5A5A_5A5A_5A5A;
    endtask

    task automatic test_reset();
        n_vec++;
        if ({in_ready, mem_if.mem_req_valid, out_valid, out_misalign, out_bus_err, mem_if.mem_wen, mem_if.mem_wmask} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            n_bad++;
            $display("FAIL reset_ctrl got rdy=%0b rv=%0b ov=%0b mis=%0b err=%0b wen=%0b mask=%h want 1 0 0 0 0 0 00",
                     in_ready, mem_if.mem_req_valid, out_valid, out_misalign, out_bus_err, mem_if.mem_wen, mem_if.mem_wmask);
        end
        n_vec++;
        if ({mem_if.mem_addr, mem_if.mem_wdata, out_load_data} !== 192'd0) begin
            n_bad++;
            $display("FAIL reset_data got addr=%h wdata=%h data=%h want all 0", mem_if.mem_addr, mem_if.mem_wdata, out_load_data);
        end
    endtask

    task automatic test_patterns();
        pat_t p[12];
        p[0]  = '{2'b00, 64'h8000_0005, 64'hAB, 1'b0, 1'b1, 1'b0, 64'h0123_4567_89AB_CDEF, 8'h20, 64'hABAB_ABAB_ABAB_ABAB, 64'h0};
        p[1]  = '{2'b01, 64'h8000_0006, 64'h0, 1'b1, 1'b0, 1'b0, 64'h8001_0000_0000_0000, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_8001};
        p[2]  = '{2'b01, 64'h8000_0006, 64'h0, 1'b1, 1'b0, 1'b1, 64'h8001_0000_0000_0000, 8'h00, 64'h0, 64'h0000_0000_0000_8001};
        p[3]  = '{2'b00, 64'h8000_0003, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0123_4567_F9AB_CDEF, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FFF9};
        p[4]  = '{2'b00, 64'h8000_0003, 64'h0, 1'b1, 1'b0, 1'b1, 64'h0123_4567_F9AB_CDEF, 8'h00, 64'h0, 64'h0000_0000_0000_00F9};
        p[5]  = '{2'b10, 64'h8000_0004, 64'h0, 1'b1, 1'b0, 1'b0, 64'h8765_4321_0000_0000, 8'h00, 64'h0, 64'hFFFF_FFFF_8765_4321};
        p[6]  = '{2'b11, 64'h8000_0008, 64'h0, 1'b1, 1'b0, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, 8'h00, 64'h0, 64'hDEAD_BEEF_CAFE_F00D};
        p[7]  = '{2'b10, 64'h8000_0104, 64'h1122_3344_5566_7788, 1'b0, 1'b1, 1'b0, 64'h0, 8'hF0, 64'h5566_7788_5566_7788, 64'h0};
        p[8]  = '{2'b01, 64'h8000_000A, 64'hBEEF, 1'b0, 1'b1, 1'b0, 64'h0, 8'h0C, 64'hBEEF_BEEF_BEEF_BEEF, 64'h0};
        p[9]  = '{2'b11, 64'h8000_0010, 64'h0102_0304_0506_0708, 1'b0, 1'b1, 1'b0, 64'h0, 8'hFF, 64'h0102_0304_0506_0708, 64'h0};
        p[10] = '{2'b00, 64'h8000_0001, 64'h5A, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h02, 64'h5A5A_5A5A_5A5A_5A5A, 64'h0};
        p[11] = '{2'b00, 64'h8000_0007, 64'h0, 1'b1, 1'b0, 1'b0, 64'h7F00_0000_0000_0000, 8'h00, 64'h0, 64'h0000_0000_0000_007F};
        for (int i = 0; i < 12; i++) begin
            logic [63:0] exp_addr;
            exp_addr = {p[i].loc[63:3], 3'b000};
            issue(p[i].t, p[i].loc, p[i].sd, p[i].ld, p[i].st, p[i].uns, '{p[i].res, 1'b0, 1'b0});
            n_vec++;
            if ({mem_if.mem_req_valid, mem_if.mem_wen, mem_if.mem_wmask, mem_if.mem_addr} !== {1'b1, p[i].st, p[i].wmask, exp_addr}) begin
                n_bad++;
                $display("FAIL pat%0d_req got rv=%0b wen=%0b mask=%h addr=%h want 1 %0b %h %h", i,
                         mem_if.mem_req_valid, mem_if.mem_wen, mem_if.mem_wmask, mem_if.mem_addr, p[i].st, p[i].wmask, exp_addr);
            end
            if (p[i].st) begin
                n_vec++;
                if (mem_if.mem_wdata !== p[i].wdata) begin
                    n_bad++;
                    $display("FAIL pat%0d_wdata got %h want %h", i, mem_if.mem_wdata, p[i].wdata);
                end
            end
            bus_cycle(p[i].rd);
            n_vec++;
            if (out_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL pat%0d_latency got out_valid=%0b want 1", i, out_valid);
            end
            step();
        end
    endtask

    task automatic test_misaligned();
        logic [1:0]  ts[4];
        logic [63:0] ls[4];
        logic        ens[4];
        ts[0] = 2'b10; ls[0] = 64'h8000_0002; ens[0] = 1'b1;
        ts[1] = 2'b01; ls[1] = 64'h8000_0001; ens[1] = 1'b1;
        ts[2] = 2'b11; ls[2] = 64'h8000_0004; ens[2] = 1'b1;
        ts[3] = 2'b11; ls[3] = 64'h8000_0000; ens[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(ts[i], ls[i], 64'h0, ens[i], 1'b0, 1'b0, '{64'h0, ens[i], 1'b0});
            n_vec++;
            if ({mem_if.mem_req_valid, out_valid, out_misalign} !== {1'b0, 1'b1, ens[i]}) begin
                n_bad++;
                $display("FAIL misalign%0d got rv=%0b ov=%0b mis=%0b want 0 1 %0b", i,
                         mem_if.mem_req_valid, out_valid, out_misalign, ens[i]);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        int r0;
        r0 = req_cnt;
        issue(2'b11, 64'h8000_0018, 64'h0, 1'b1, 1'b0, 1'b0, '{64'h0F1E_2D3C_4B5A_6978, 1'b0, 1'b0});
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({mem_if.mem_req_valid, mem_if.mem_addr} !== {1'b1, 64'h8000_0018}) begin
                n_bad++;
                $display("FAIL bp_req%0d got rv=%0b addr=%h want 1 80000018", i, mem_if.mem_req_valid, mem_if.mem_addr);
            end
            step();
        end
        bus_cycle(64'h0F1E_2D3C_4B5A_6978);
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_if.mem_rsp_valid = 1'b1;
            n_vec++;
            if ({out_valid, out_load_data} !== {1'b1, 64'h0F1E_2D3C_4B5A_6978}) begin
                n_bad++;
                $display("FAIL bp_hold%0d got ov=%0b data=%h want 1 0f1e2d3c4b5a6978", i, out_valid, out_load_data);
            end
            step();
        end
        mem_if.mem_rsp_valid = 1'b0;
        out_ready = 1'b1;
        step();
        n_vec++;
        if (req_cnt - r0 !== 1) begin
            n_bad++;
            $display("FAIL bp_req_count got %0d want 1", req_cnt - r0);
        end
    endtask

    task automatic test_timeout();
        issue(2'b10, 64'h8000_0020, 64'h0, 1'b1, 1'b0, 1'b0, '{64'h0, 1'b0, 1'b1});
        mem_if.mem_req_ready = 1'b1;
        step();
        mem_if.mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL to_early%0d got ov=%0b want 0", i, out_valid);
            end
            step();
        end
        n_vec++;
        if ({out_valid, out_bus_err} !== 2'b11) begin
            n_bad++;
            $display("FAIL to_err got ov=%0b err=%0b want 1 1", out_valid, out_bus_err);
        end
        step();
        mem_if.mem_rsp_valid = 1'b1;
        mem_if.mem_rsp_rdata = 64'hFFFF_0000_FFFF_0000;
        step();
        mem_if.mem_rsp_valid = 1'b0;
        n_vec++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL to_late_rsp got ov=%0b rdy=%0b want 0 1", out_valid, in_ready);
        end
        issue(2'b00, 64'h8000_0027, 64'h0, 1'b1, 1'b0, 1'b1, '{64'h0000_0000_0000_00AA, 1'b0, 1'b0});
        bus_cycle(64'hAA00_0000_0000_0000);
        step();
        // Response lands in the last WAIT cycle, together with the timeout.
        issue(2'b10, 64'h8000_0030, 64'h0, 1'b1, 1'b0, 1'b1, '{64'h0000_0000_1234_5678, 1'b0, 1'b0});
        mem_if.mem_req_ready = 1'b1;
        step();
        mem_if.mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        mem_if.mem_rsp_valid = 1'b1;
        mem_if.mem_rsp_rdata = 64'h0000_0000_1234_5678;
        step();
        mem_if.mem_rsp_valid = 1'b0;
        n_vec++;
        if ({out_valid, out_bus_err} !== 2'b10) begin
            n_bad++;
            $display("FAIL to_tie got ov=%0b err=%0b want 1 0", out_valid, out_bus_err);
        end
        step();
    endtask

    task automatic test_reset_mid();
        issue(2'b11, 64'h8000_0040, 64'h0, 1'b1, 1'b0, 1'b0, '{64'h0, 1'b0, 1'b0});
        void'(sb.pop_back());
        mem_if.mem_req_ready = 1'b1;
        step();
        mem_if.mem_req_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        test_reset();
        mem_if.mem_rsp_valid = 1'b1;
        mem_if.mem_rsp_rdata = 64'h1111_2222_3333_4444;
        step();
        mem_if.mem_rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({out_valid, mem_if.mem_req_valid} !== 2'b00) begin
                n_bad++;
                $display("FAIL rst_stale%0d got ov=%0b rv=%0b want 0 0", i, out_valid, mem_if.mem_req_valid);
            end
            step();
        end
        issue(2'b01, 64'h8000_0042, 64'h0, 1'b1, 1'b0, 1'b0, '{64'h0000_0000_0000_7FFE, 1'b0, 1'b0});
        bus_cycle(64'h0000_0000_7FFE_0000);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got no finish want finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; ls_loc = 64'h0; store_data = 64'h0;
        load_en = 1'b0; store_en = 1'b0; ls_type = 2'b00; load_unsigned = 1'b0;
        out_ready = 1'b1;
        mem_if.mem_req_ready = 1'b0;
        mem_if.mem_rsp_valid = 1'b1;
        mem_if.mem_rsp_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
        step();
        step();
        rst = 1'b0;
        mem_if.mem_rsp_valid = 1'b0;
        test_reset();
        test_patterns();
        test_misaligned();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        step();
        n_vec++;
        if (sb.size() !== 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
